// File: rtl/axis_i2c_pkg.sv
// Shared types and default widths for the I2C <-> AXI-Stream bridge blocks.
// The word layout {addr, rw, data} is common to the transmitter and receiver.
package axis_i2c_pkg;

    localparam int unsigned DEF_I2C_ADDR_WIDTH  = 7;
    localparam int unsigned DEF_I2C_DATA_WIDTH  = 8;
    localparam int unsigned DEF_AXIS_DATA_WIDTH = DEF_I2C_DATA_WIDTH * 2;

    // Receiver protocol states
    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ACK_ADDR,
        S_DATA,
        S_ACK_DATA,
        S_IGNORE
    } i2c_rx_state_e;

endpackage

// File: rtl/axis_if.sv
// AXI-Stream channel bundle (tdata/tvalid/tready only).
//   master: drives tdata, tvalid; receives tready
//   slave : receives tdata, tvalid; drives tready
interface axis_if #(
    parameter int unsigned DATA_WIDTH = 16
) ();
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_i2c_bus_sync.sv
// I2C bus synchronizer and event detector.
// Brings SCL/SDA into the clk domain with 2-flop synchronizers (reset to the
// idle-high bus level) and emits registered single-cycle event pulses.
//   clk, arstn   : system clock, async active-low reset
//   i_scl, i_sda : raw bus pins, asynchronous to clk
//   o_scl_rise   : SCL rising edge detected
//   o_scl_fall   : SCL falling edge detected
//   o_start      : SDA fell while SCL high
//   o_stop       : SDA rose while SCL high
//   o_sda        : synchronized SDA, time-aligned with the pulses
module i2c_bus_sync (
    input  logic clk,
    input  logic arstn,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop,
    output logic o_sda
);

    logic [1:0] r_scl_sync;
    logic [1:0] r_sda_sync;
    logic       r_scl_d;
    logic       r_sda_d;

    // Synchronizers, one-cycle history and registered event pulses
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_scl_sync <= 2'b11;
            r_sda_sync <= 2'b11;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
            o_scl_rise <= 1'b0;
            o_scl_fall <= 1'b0;
            o_start    <= 1'b0;
            o_stop     <= 1'b0;
            o_sda      <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[0], i_scl};
            r_sda_sync <= {r_sda_sync[0], i_sda};
            r_scl_d    <= r_scl_sync[1];
            r_sda_d    <= r_sda_sync[1];
            o_scl_rise <= r_scl_sync[1] & ~r_scl_d;
            o_scl_fall <= ~r_scl_sync[1] & r_scl_d;
            // SCL must be high on both samples so an SCL edge never aliases a START/STOP
            o_start    <= r_scl_sync[1] & r_scl_d & r_sda_d & ~r_sda_sync[1];
            o_stop     <= r_scl_sync[1] & r_scl_d & ~r_sda_d & r_sda_sync[1];
            o_sda      <= r_sda_sync[1];
        end
    end

endmodule

// File: rtl/axis_i2c_receiver.sv
// I2C target receiver feeding an AXI-Stream master.
// Decodes START/STOP, address+RW and data bytes from the synchronized bus,
// ACKs its own write address and each byte it can buffer, and presents each
// accepted byte as one beat {addr, rw, data}.
//   clk, arstn : system clock, async active-low reset
//   scl_i      : bus clock pin
//   sda_i      : bus data pin
//   sda_oe     : 1 = pull SDA low (ACK)
//   rx_drop    : one-cycle pulse when a byte is NACKed because the buffer is full
//   m_axis     : AXI-Stream master, tdata = {addr, rw, data}
module axis_i2c_receiver
    import axis_i2c_pkg::*;
#(
    parameter int unsigned                   I2C_ADDR_WIDTH  = DEF_I2C_ADDR_WIDTH,
    parameter int unsigned                   I2C_DATA_WIDTH  = DEF_I2C_DATA_WIDTH,
    parameter int unsigned                   AXIS_DATA_WIDTH = I2C_DATA_WIDTH * 2,
    parameter logic [I2C_ADDR_WIDTH-1:0]     OWN_ADDR        = I2C_ADDR_WIDTH'(7'h2A),
    parameter bit                            LSB_FIRST       = 1'b1
) (
    input  logic   clk,
    input  logic   arstn,
    input  logic   scl_i,
    input  logic   sda_i,
    output logic   sda_oe,
    output logic   rx_drop,
    axis_if.master m_axis
);

    localparam int unsigned CNT_MAX = (I2C_ADDR_WIDTH + 1 > I2C_DATA_WIDTH) ?
                                      I2C_ADDR_WIDTH + 1 : I2C_DATA_WIDTH;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(I2C_ADDR_WIDTH - 1);
    localparam logic [CNT_W-1:0] RW_IDX    = CNT_W'(I2C_ADDR_WIDTH);
    localparam logic [CNT_W-1:0] ADDR_BITS = CNT_W'(I2C_ADDR_WIDTH + 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(I2C_DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] DATA_BITS = CNT_W'(I2C_DATA_WIDTH);

    logic w_scl_rise;
    logic w_scl_fall;
    logic w_start;
    logic w_stop;
    logic w_sda;

    i2c_rx_state_e r_state;
    i2c_rx_state_e w_state_next;

    logic [CNT_W-1:0]           r_cnt;
    logic [I2C_ADDR_WIDTH-1:0]  r_addr;
    logic                       r_rw;
    logic [I2C_DATA_WIDTH-1:0]  r_data;
    logic                       r_ack_ok;
    logic                       r_sda_oe;
    logic                       w_sda_oe_next;
    logic                       r_rx_drop;
    logic [AXIS_DATA_WIDTH-1:0] r_tdata;
    logic                       r_tvalid;

    logic                       w_match;
    logic                       w_load_ok;
    logic [CNT_W-1:0]           w_addr_idx;
    logic [CNT_W-1:0]           w_data_idx;
    logic [I2C_ADDR_WIDTH-1:0]  w_addr_ins;
    logic [I2C_DATA_WIDTH-1:0]  w_data_ins;

    i2c_bus_sync u_sync (
        .clk        (clk),
        .arstn      (arstn),
        .i_scl      (scl_i),
        .i_sda      (sda_i),
        .o_scl_rise (w_scl_rise),
        .o_scl_fall (w_scl_fall),
        .o_start    (w_start),
        .o_stop     (w_stop),
        .o_sda      (w_sda)
    );

    assign w_match    = (r_addr == OWN_ADDR) && !r_rw;
    // A beat leaving this cycle frees the buffer for the incoming byte
    assign w_load_ok  = !r_tvalid || m_axis.tready;
    assign w_addr_idx = LSB_FIRST ? r_cnt : (ADDR_LAST - r_cnt);
    assign w_data_idx = LSB_FIRST ? r_cnt : (DATA_LAST - r_cnt);

    // Current address/data with the bit being sampled inserted at its position
    always_comb begin
        w_addr_ins = r_addr;
        w_data_ins = r_data;
        for (int i = 0; i < int'(I2C_ADDR_WIDTH); i++) begin
            if (CNT_W'(i) == w_addr_idx) w_addr_ins[i] = w_sda;
        end
        for (int i = 0; i < int'(I2C_DATA_WIDTH); i++) begin
            if (CNT_W'(i) == w_data_idx) w_data_ins[i] = w_sda;
        end
    end

    // State register (also holds the registered SDA drive)
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_state  <= S_IDLE;
            r_sda_oe <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_sda_oe <= w_sda_oe_next;
        end
    end

    // Next-state logic; STOP/START override everything else
    always_comb begin
        w_state_next = r_state;
        if (w_stop) begin
            w_state_next = S_IDLE;
        end else if (w_start) begin
            w_state_next = S_ADDR;
        end else begin
            case (r_state)
                S_ADDR:     if (w_scl_fall && r_cnt == ADDR_BITS) w_state_next = S_ACK_ADDR;
                S_ACK_ADDR: if (w_scl_fall) w_state_next = w_match ? S_DATA : S_IGNORE;
                S_DATA:     if (w_scl_fall && r_cnt == DATA_BITS) w_state_next = S_ACK_DATA;
                S_ACK_DATA: if (w_scl_fall) w_state_next = S_DATA;
                S_IDLE,
                S_IGNORE:   w_state_next = r_state;
                default:    w_state_next = S_IDLE;
            endcase
        end
    end

    // SDA drive; only moves on SCL fall apart from bus conditions
    always_comb begin
        w_sda_oe_next = r_sda_oe;
        if (w_stop || w_start) begin
            w_sda_oe_next = 1'b0;
        end else begin
            case (r_state)
                S_ADDR:     if (w_scl_fall && r_cnt == ADDR_BITS) w_sda_oe_next = w_match;
                S_DATA:     if (w_scl_fall && r_cnt == DATA_BITS) w_sda_oe_next = r_ack_ok;
                S_ACK_ADDR,
                S_ACK_DATA: if (w_scl_fall) w_sda_oe_next = 1'b0;
                default:    w_sda_oe_next = 1'b0;
            endcase
        end
    end

    // Bit counter, shift registers and single-entry output buffer
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_cnt     <= '0;
            r_addr    <= '0;
            r_rw      <= 1'b0;
            r_data    <= '0;
            r_ack_ok  <= 1'b0;
            r_rx_drop <= 1'b0;
            r_tdata   <= '0;
            r_tvalid  <= 1'b0;
        end else begin
            r_rx_drop <= 1'b0;
            if (r_tvalid && m_axis.tready) r_tvalid <= 1'b0;

            if (w_start || w_stop) begin
                r_cnt <= '0;
            end else begin
                case (r_state)
                    S_ADDR: begin
                        if (w_scl_rise && r_cnt < ADDR_BITS) begin
                            r_cnt <= r_cnt + CNT_W'(1);
                            if (r_cnt == RW_IDX) r_rw   <= w_sda;
                            else                 r_addr <= w_addr_ins;
                        end
                    end
                    S_DATA: begin
                        if (w_scl_rise && r_cnt < DATA_BITS) begin
                            r_cnt  <= r_cnt + CNT_W'(1);
                            r_data <= w_data_ins;
                            if (r_cnt == DATA_LAST) begin
                                if (w_load_ok) begin
                                    r_tdata  <= AXIS_DATA_WIDTH'({r_addr, r_rw, w_data_ins});
                                    r_tvalid <= 1'b1;
                                    r_ack_ok <= 1'b1;
                                end else begin
                                    r_rx_drop <= 1'b1;
                                    r_ack_ok  <= 1'b0;
                                end
                            end
                        end
                    end
                    S_ACK_ADDR,
                    S_ACK_DATA: if (w_scl_fall) r_cnt <= '0;
                    default: ;
                endcase
            end
        end
    end

    assign sda_oe        = r_sda_oe;
    assign rx_drop       = r_rx_drop;
    assign m_axis.tdata  = r_tdata;
    assign m_axis.tvalid = r_tvalid;

endmodule

// File: tb/tb_axis_i2c_receiver.sv
// Directed bench for axis_i2c_receiver: bit-banged I2C master, open-drain
// SDA wire, beat monitor and expected-beat scoreboard.
module tb_axis_i2c_receiver;

    logic clk = 1'b0;
    logic arstn;
    logic scl_i;
    logic sda_drv;
    logic sda_i;
    logic sda_oe;
    logic rx_drop;
    logic tb_tready;

    axis_if #(.DATA_WIDTH(16)) axis ();

    assign sda_i       = sda_drv & ~sda_oe;
    assign axis.tready = tb_tready;

    axis_i2c_receiver dut (
        .clk     (clk),
        .arstn   (arstn),
        .scl_i   (scl_i),
        .sda_i   (sda_i),
        .sda_oe  (sda_oe),
        .rx_drop (rx_drop),
        .m_axis  (axis)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int t_low = 10;
    int t_high = 10;

    logic [15:0] obs_q[$];
    logic [15:0] exp_q[$];

    // Monitor state, written only by the monitor process
    int          cyc_n = 0;
    int          rise_cyc = 0;
    int          last_lat = -1;
    int          drop_cnt = 0;
    int          oe_cnt = 0;
    int          unstable = 0;
    logic        scl_prev = 1'b1;
    logic        tv_prev = 1'b0;
    logic        rdy_prev = 1'b0;
    logic [15:0] data_prev = '0;

    always @(negedge clk) begin
        cyc_n++;
        if (scl_i && !scl_prev) rise_cyc = cyc_n;
        scl_prev = scl_i;
        if (arstn) begin
            if (axis.tvalid && !tv_prev) last_lat = cyc_n - rise_cyc;
            if (axis.tvalid && axis.tready) obs_q.push_back(axis.tdata);
            if (rx_drop) drop_cnt++;
            if (sda_oe) oe_cnt++;
            if (tv_prev && !rdy_prev && (!axis.tvalid || axis.tdata != data_prev)) unstable++;
        end
        tv_prev   = axis.tvalid;
        rdy_prev  = axis.tready;
        data_prev = axis.tdata;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drain(input string tag);
        chk({tag, "_beats"}, 32'(obs_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0)
            chk(tag, 32'(obs_q.pop_front()), 32'(exp_q.pop_front()));
        obs_q.delete();
        exp_q.delete();
    endtask

    // Bus primitives: each starts and ends just after SCL has gone low,
    // except i2c_start (starts idle) and i2c_stop (ends idle)
    task automatic put_bit(input logic b);
        sda_drv = b;
        cyc(t_low - 1);
        scl_i = 1'b1;
        cyc(t_high);
        scl_i = 1'b0;
        cyc(1);
    endtask

    task automatic get_ack(output logic ack);
        sda_drv = 1'b1;
        cyc(t_low - 1);
        scl_i = 1'b1;
        cyc(t_high / 2);
        ack = ~sda_i;
        cyc(t_high - t_high / 2);
        scl_i = 1'b0;
        cyc(1);
    endtask

    task automatic i2c_start();
        sda_drv = 1'b1;
        scl_i   = 1'b1;
        cyc(t_high);
        sda_drv = 1'b0;
        cyc(t_high);
        scl_i = 1'b0;
        cyc(1);
    endtask

    task automatic i2c_rstart();
        sda_drv = 1'b1;
        cyc(t_low - 1);
        scl_i = 1'b1;
        cyc(t_high);
        sda_drv = 1'b0;
        cyc(t_high);
        scl_i = 1'b0;
        cyc(1);
    endtask

    task automatic i2c_stop();
        sda_drv = 1'b0;
        cyc(t_low - 1);
        scl_i = 1'b1;
        cyc(t_high);
        sda_drv = 1'b1;
        cyc(t_high);
    endtask

    task automatic addr_phase(input logic [6:0] a, input logic rw, output logic ack);
        for (int i = 0; i < 7; i++) put_bit(a[i]);
        put_bit(rw);
        get_ack(ack);
    endtask

    task automatic data_phase(input logic [7:0] d, output logic ack);
        for (int i = 0; i < 8; i++) put_bit(d[i]);
        get_ack(ack);
    endtask

    logic ack;
    int   base_drop;
    int   base_oe;
    int   base_unst;

    initial begin
        arstn     = 1'b0;
        scl_i     = 1'b1;
        sda_drv   = 1'b1;
        tb_tready = 1'b1;
        cyc(5);
        chk("rst_sda_oe", 32'(sda_oe), 32'd0);
        chk("rst_rx_drop", 32'(rx_drop), 32'd0);
        chk("rst_tvalid", 32'(axis.tvalid), 32'd0);
        chk("rst_tdata", 32'(axis.tdata), 32'h0);
        arstn = 1'b1;
        cyc(5);

        // Single write
        base_drop = drop_cnt;
        i2c_start();
        addr_phase(7'h2A, 1'b0, ack);
        chk("single_addr_ack", 32'(ack), 32'd1);
        data_phase(8'hA5, ack);
        exp_q.push_back(16'h54A5);
        chk("single_data_ack", 32'(ack), 32'd1);
        i2c_stop();
        cyc(5);
        drain("single");
        chk("single_drop", 32'(drop_cnt - base_drop), 32'd0);
        chk("single_tvalid_lat", 32'(last_lat), 32'd4);

        // Address mismatch
        base_oe = oe_cnt;
        i2c_start();
        addr_phase(7'h2B, 1'b0, ack);
        chk("mismatch_addr_ack", 32'(ack), 32'd0);
        data_phase(8'h11, ack);
        chk("mismatch_data_ack", 32'(ack), 32'd0);
        i2c_stop();
        cyc(5);
        chk("mismatch_sda_oe_cycles", 32'(oe_cnt - base_oe), 32'd0);
        drain("mismatch");

        // Read bit: NACK then ignore until STOP
        i2c_start();
        addr_phase(7'h2A, 1'b1, ack);
        chk("read_addr_ack", 32'(ack), 32'd0);
        data_phase(8'h77, ack);
        chk("read_ignore_ack", 32'(ack), 32'd0);
        i2c_stop();
        cyc(5);
        drain("read");

        // Backpressure
        tb_tready = 1'b0;
        base_drop = drop_cnt;
        base_unst = unstable;
        i2c_start();
        addr_phase(7'h2A, 1'b0, ack);
        chk("bp_addr_ack", 32'(ack), 32'd1);
        data_phase(8'h11, ack);
        exp_q.push_back(16'h5411);
        chk("bp_first_ack", 32'(ack), 32'd1);
        data_phase(8'h22, ack);
        chk("bp_second_nack", 32'(ack), 32'd0);
        i2c_stop();
        cyc(5);
        chk("bp_drop_cycles", 32'(drop_cnt - base_drop), 32'd1);
        chk("bp_held_tvalid", 32'(axis.tvalid), 32'd1);
        chk("bp_held_tdata", 32'(axis.tdata), 32'h5411);
        chk("bp_no_early_beat", 32'(obs_q.size()), 32'd0);
        tb_tready = 1'b1;
        cyc(4);
        chk("bp_tvalid_cleared", 32'(axis.tvalid), 32'd0);
        chk("bp_stable", 32'(unstable - base_unst), 32'd0);
        drain("bp");

        // Repeated start
        i2c_start();
        addr_phase(7'h2A, 1'b0, ack);
        chk("sr_addr1_ack", 32'(ack), 32'd1);
        data_phase(8'h33, ack);
        exp_q.push_back(16'h5433);
        chk("sr_data1_ack", 32'(ack), 32'd1);
        i2c_rstart();
        addr_phase(7'h2A, 1'b0, ack);
        chk("sr_addr2_ack", 32'(ack), 32'd1);
        data_phase(8'h44, ack);
        exp_q.push_back(16'h5444);
        chk("sr_data2_ack", 32'(ack), 32'd1);
        i2c_stop();
        cyc(5);
        drain("sr");

        // Reset mid-byte
        i2c_start();
        addr_phase(7'h2A, 1'b0, ack);
        for (int i = 0; i < 4; i++) put_bit(1'b1);
        arstn = 1'b0;
        #2;
        chk("midrst_sda_oe", 32'(sda_oe), 32'd0);
        chk("midrst_rx_drop", 32'(rx_drop), 32'd0);
        chk("midrst_tvalid", 32'(axis.tvalid), 32'd0);
        chk("midrst_tdata", 32'(axis.tdata), 32'h0);
        sda_drv = 1'b1;
        scl_i   = 1'b1;
        cyc(3);
        arstn = 1'b1;
        cyc(5);

        // Fresh frame, nominal then minimum SCL timing
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) begin
                t_low  = 8;
                t_high = 6;
            end
            i2c_start();
            addr_phase(7'h2A, 1'b0, ack);
            chk("post_rst_addr_ack", 32'(ack), 32'd1);
            data_phase(8'h5A, ack);
            exp_q.push_back(16'h545A);
            chk("post_rst_data_ack", 32'(ack), 32'd1);
            i2c_stop();
            cyc(5);
            drain("post_rst");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
